execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports ALUControl input 5, ALUSrc input 1, RegDst input 1, Jal input 1: control fields from the decode-to-execute register.
REQ-004 SHALL have ports ReadData1, ReadData2, SignExt, PCAddResult  input  32 each  operands and PC+4 from the decode-to-execute register.
REQ-005 SHALL have ports RegDst1, RegDst2  input  5 each  rt and rd fields.
REQ-006 SHALL have port ALUResult  output  32  combinational result to the execute-to-memory register.
REQ-007 SHALL have port Zero  output  1  high when ALUResult == 0.
REQ-008 SHALL have port WriteReg  output  5  destination register number.
REQ-009 SHALL have port Stall  output  1  high = hold the decode-to-execute register and all upstream stages.

Function
REQ-010 SHALL select operand B = SignExt when ALUSrc=1, else ReadData2; operand A = ReadData1.
REQ-011 SHALL decode ALUControl as: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 NOR, 00110 SLT (signed), 00111 SLL, 01000 SRL, 01001 SRA, 01010 MULT, 01011 MULTU, 01100 MFHI, 01101 MFLO, 01110 MTHI, 01111 MTLO, 10000 LUI; all other codes give ALUResult=0 and no state change.
REQ-012 SHALL shift B by SignExt[10:6] for SLL/SRL/SRA; LUI gives {B[15:0],16'h0}; ADD/SUB wrap modulo 2^32, no overflow trap.
REQ-013 SHALL give ALUResult=PCAddResult when Jal=1, overriding ALUControl.
REQ-014 SHALL give WriteReg=31 when Jal=1, else RegDst2 when RegDst=1, else RegDst1.
REQ-015 SHALL hold 32-bit HI and LO registers; MFHI/MFLO return the current value combinationally; MTHI/MTLO write A into HI/LO at the clock edge (state IDLE only).
REQ-016 SHALL run MULT/MULTU through a three-state FSM: IDLE, BUSY, DONE.
REQ-017 IDLE: on MULT/MULTU, latch A, B, signedness, clear 5-bit counter and 64-bit accumulator, go to BUSY; otherwise stay.
REQ-018 BUSY: one shift-add iteration per cycle on operand magnitudes; after the 32nd iteration (counter=31) write the 64-bit product (negated when signed and sign(A)!=sign(B)) into {HI,LO} and go to DONE.
REQ-019 DONE: unconditionally go to IDLE next cycle; a MULT/MULTU at the inputs in DONE SHALL NOT start a new operation.
REQ-020 Stall SHALL equal (state==IDLE and ALUControl is MULT/MULTU and Jal=0) or state==BUSY; Stall is 0 in DONE.
REQ-021 Total stall for one multiply SHALL be exactly 33 cycles (issue + 32 BUSY); the instruction leaves in the DONE cycle.
REQ-022 ALUResult for MULT/MULTU SHALL be 0; MFHI/MFLO in the cycle after DONE SHALL see the new product.
REQ-023 Inputs are held stable by upstream while Stall=1; the block SHALL use latched operands in BUSY regardless.

Reset
REQ-024 Reset SHALL asynchronously force state=IDLE, counter=0, accumulator=0, HI=0, LO=0.
REQ-025 Reset during BUSY SHALL abort the multiply with HI/LO=0 and Stall=0 while Reset is held.
REQ-026 Combinational outputs SHALL follow inputs during reset; Stall SHALL be 0.

Structure
REQ-027 ALUControl opcodes and FSM state encodings SHALL live in a shared package used by the controller and this block.
REQ-028 The iterative multiplier (operand latch, counter, accumulator, sign fix-up) SHALL be one sub-module, mul_iter, with start/busy/done and a 64-bit product.

Verification
REQ-029 ADD A=0x7FFFFFFF, B=1 -> ALUResult=0x80000000, Zero=0; SUB A=B=5 -> Zero=1.
REQ-030 SRA B=0x80000000, SignExt[10:6]=4 -> 0xF8000000; LUI SignExt=0x1234 with ALUSrc=1 -> 0x12340000.
REQ-031 MULT A=-3, B=7 -> Stall high 33 cycles, DONE cycle Stall=0, then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB.
REQ-032 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT held at inputs in DONE starts no second multiply.
REQ-033 Reset asserted at BUSY cycle 10 -> immediate IDLE, Stall=0, HI=LO=0; subsequent MULT 2*3 -> LO=6.
REQ-034 Jal=1, PCAddResult=0x00400008, RegDst=1 -> ALUResult=0x00400008, WriteReg=31, Stall=0 even if ALUControl=MULT.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared ALU opcodes, multiplier FSM encodings and widths for the execute stage and its controller.
package execute_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 5'b00000,
        ALU_SUB   = 5'b00001,
        ALU_AND   = 5'b00010,
        ALU_OR    = 5'b00011,
        ALU_XOR   = 5'b00100,
        ALU_NOR   = 5'b00101,
        ALU_SLT   = 5'b00110,
        ALU_SLL   = 5'b00111,
        ALU_SRL   = 5'b01000,
        ALU_SRA   = 5'b01001,
        ALU_MULT  = 5'b01010,
        ALU_MULTU = 5'b01011,
        ALU_MFHI  = 5'b01100,
        ALU_MFLO  = 5'b01101,
        ALU_MTHI  = 5'b01110,
        ALU_MTLO  = 5'b01111,
        ALU_LUI   = 5'b10000
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // True for the two opcodes that launch the iterative multiplier.
    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute operands/controls in, execute-to-memory results and stall out.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic [OP_W-1:0]   ALUControl;
    logic              ALUSrc;
    logic              RegDst;
    logic              Jal;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] SignExt;
    logic [DATA_W-1:0] PCAddResult;
    logic [REG_W-1:0]  RegDst1;
    logic [REG_W-1:0]  RegDst2;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;
    logic [REG_W-1:0]  WriteReg;
    logic              Stall;

    modport master (
        output ALUControl, ALUSrc, RegDst, Jal, ReadData1, ReadData2, SignExt,
               PCAddResult, RegDst1, RegDst2,
        input  ALUResult, Zero, WriteReg, Stall
    );

    modport slave (
        input  ALUControl, ALUSrc, RegDst, Jal, ReadData1, ReadData2, SignExt,
               PCAddResult, RegDst1, RegDst2,
        output ALUResult, Zero, WriteReg, Stall
    );

endinterface

// File: rtl/execute_stage_mul_iter.sv
// Iterative 32x32 shift-add multiplier: one partial product per cycle on magnitudes, sign fixed at the end.
module mul_iter
    import execute_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_idle,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wr_c,
    output logic [PROD_W-1:0] o_product_c
);

    mul_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [PROD_W-1:0] r_acc, w_acc_nxt;
    logic [DATA_W-1:0] r_a, w_a_nxt;
    logic [DATA_W-1:0] r_b, w_b_nxt;
    logic              r_neg, w_neg_nxt;
    logic [PROD_W-1:0] w_addend;
    logic [PROD_W-1:0] w_sum;
    logic [DATA_W-1:0] w_mag_a;
    logic [DATA_W-1:0] w_mag_b;

    assign o_idle = (r_state == ST_IDLE);
    assign o_busy = (r_state == ST_BUSY);
    assign o_done = (r_state == ST_DONE);

    // Magnitudes of the incoming operands (two's-complement abs for signed, raw for unsigned).
    assign w_mag_a = (i_signed && i_a[DATA_W-1]) ? (~i_a + DATA_W'(1)) : i_a;
    assign w_mag_b = (i_signed && i_b[DATA_W-1]) ? (~i_b + DATA_W'(1)) : i_b;

    // Partial product for the current bit and the final signed product.
    assign w_addend    = r_b[r_cnt] ? (PROD_W'(r_a) << r_cnt) : '0;
    assign w_sum       = r_acc + w_addend;
    assign o_product_c = r_neg ? (~w_sum + PROD_W'(1)) : w_sum;
    assign o_wr_c      = (r_state == ST_BUSY) && (r_cnt == CNT_W'(DATA_W - 1));

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    // Next-state: latch on start, 32 shift-add iterations, one DONE cycle that ignores new requests.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_neg_nxt   = r_neg;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_a_nxt     = w_mag_a;
                    w_b_nxt     = w_mag_b;
                    w_neg_nxt   = i_signed && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_acc_nxt = w_sum;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (o_wr_c) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, destination select, HI/LO registers and multiply stall control.
module execute_stage
    import execute_stage_pkg::*;
(
    input logic            Clk,
    input logic            Reset,
    execute_stage_if.slave bus
);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [CNT_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_alu;
    logic              w_is_mul;
    logic              w_start;
    logic              w_idle;
    logic              w_busy;
    logic              w_done;
    logic              w_wr;
    logic [PROD_W-1:0] w_product;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    assign w_a      = bus.ReadData1;
    assign w_b      = bus.ALUSrc ? bus.SignExt : bus.ReadData2;
    assign w_shamt  = bus.SignExt[10:6];
    assign w_is_mul = is_mul_op(bus.ALUControl);
    assign w_start  = w_idle && w_is_mul && !bus.Jal;

    mul_iter u_mul (
        .clk         (Clk),
        .rst         (Reset),
        .i_start     (w_start),
        .i_signed    (bus.ALUControl == ALU_MULT),
        .i_a         (w_a),
        .i_b         (w_b),
        .o_idle      (w_idle),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_wr_c      (w_wr),
        .o_product_c (w_product)
    );

    // HI/LO: product write at the last multiply iteration, MTHI/MTLO only from IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_wr) begin
            r_hi <= w_product[PROD_W-1:DATA_W];
            r_lo <= w_product[DATA_W-1:0];
        end else if (w_idle && !bus.Jal) begin
            if (bus.ALUControl == ALU_MTHI) r_hi <= w_a;
            if (bus.ALUControl == ALU_MTLO) r_lo <= w_a;
        end
    end

    // ALU function decode; undefined codes and multiply issue give zero.
    always_comb begin
        w_alu = '0;
        case (bus.ALUControl)
            ALU_ADD:  w_alu = w_a + w_b;
            ALU_SUB:  w_alu = w_a - w_b;
            ALU_AND:  w_alu = w_a & w_b;
            ALU_OR:   w_alu = w_a | w_b;
            ALU_XOR:  w_alu = w_a ^ w_b;
            ALU_NOR:  w_alu = ~(w_a | w_b);
            ALU_SLT:  w_alu = DATA_W'($signed(w_a) < $signed(w_b));
            ALU_SLL:  w_alu = w_b << w_shamt;
            ALU_SRL:  w_alu = w_b >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(w_b) >>> w_shamt);
            ALU_MFHI: w_alu = r_hi;
            ALU_MFLO: w_alu = r_lo;
            ALU_LUI:  w_alu = {w_b[15:0], 16'h0000};
            default:  w_alu = '0;
        endcase
    end

    assign bus.ALUResult = bus.Jal ? bus.PCAddResult : w_alu;
    assign bus.Zero      = (bus.ALUResult == '0);
    assign bus.WriteReg  = bus.Jal ? REG_W'(31) : (bus.RegDst ? bus.RegDst2 : bus.RegDst1);
    assign bus.Stall     = !Reset && (w_start || w_busy);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, destination select, Jal override, HI/LO and multiplier timing.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    execute_stage_if bus ();

    execute_stage dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ALUControl = op;
        bus.ReadData1  = a;
        bus.ReadData2  = b;
        bus.ALUSrc     = 1'b0;
        bus.Jal        = 1'b0;
        bus.SignExt    = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Counts stalled cycles from the issue cycle; leaves the bench in the first non-stalled cycle.
    task automatic wait_mul(input string tag);
        int n;
        n = 1;
        check({tag, "_issue_stall"}, 32'(bus.Stall), 32'd1);
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            if (!bus.Stall) break;
            n++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
        check({tag, "_done_stall"}, 32'(bus.Stall), 32'd0);
    endtask

    initial begin
        Reset           = 1'b1;
        bus.RegDst      = 1'b0;
        bus.RegDst1     = 5'd8;
        bus.RegDst2     = 5'd17;
        bus.PCAddResult = 32'h0040_0008;
        set_op(ALU_MFHI, 32'h0, 32'h0);
        #2;
        check("rst_hi", bus.ALUResult, 32'h0);
        check("rst_stall", 32'(bus.Stall), 32'd0);
        set_op(ALU_MULT, 32'd2, 32'd3);
        #1;
        check("rst_mult_stall", 32'(bus.Stall), 32'd0);
        set_op(ALU_ADD, 32'd4, 32'd5);
        #1;
        check("rst_comb_add", bus.ALUResult, 32'd9);
        next_cycle();
        next_cycle();
        Reset = 1'b0;

        set_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        #1;
        check("add_wrap", bus.ALUResult, 32'h8000_0000);
        check("add_zero", 32'(bus.Zero), 32'd0);
        set_op(ALU_SUB, 32'd5, 32'd5);
        #1;
        check("sub_res", bus.ALUResult, 32'h0);
        check("sub_zero", 32'(bus.Zero), 32'd1);
        set_op(ALU_ADD, 32'd10, 32'd100);
        bus.ALUSrc  = 1'b1;
        bus.SignExt = 32'hFFFF_FFFF;
        #1;
        check("add_imm", bus.ALUResult, 32'd9);
        set_op(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        check("and", bus.ALUResult, 32'h0000_F000);
        set_op(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        check("or", bus.ALUResult, 32'h0000_FFF0);
        set_op(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        check("xor", bus.ALUResult, 32'h0000_0FF0);
        set_op(ALU_NOR, 32'h0, 32'h0);
        #1;
        check("nor", bus.ALUResult, 32'hFFFF_FFFF);
        set_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        #1;
        check("slt_neg", bus.ALUResult, 32'd1);
        set_op(ALU_SLT, 32'h1, 32'hFFFF_FFFF);
        #1;
        check("slt_pos", bus.ALUResult, 32'd0);
        set_op(ALU_SLL, 32'h0, 32'h1);
        bus.SignExt = 32'h0000_07C0;
        #1;
        check("sll31", bus.ALUResult, 32'h8000_0000);
        set_op(ALU_SRL, 32'h0, 32'h8000_0000);
        bus.SignExt = 32'h0000_0100;
        #1;
        check("srl4", bus.ALUResult, 32'h0800_0000);
        set_op(ALU_SRA, 32'h0, 32'h8000_0000);
        bus.SignExt = 32'h0000_0100;
        #1;
        check("sra4", bus.ALUResult, 32'hF800_0000);
        set_op(ALU_LUI, 32'h0, 32'h0);
        bus.ALUSrc  = 1'b1;
        bus.SignExt = 32'h0000_1234;
        #1;
        check("lui", bus.ALUResult, 32'h1234_0000);
        set_op(5'h11, 32'h5, 32'h6);
        #1;
        check("undef_res", bus.ALUResult, 32'h0);
        check("undef_zero", 32'(bus.Zero), 32'd1);

        check("wreg_rt", 32'(bus.WriteReg), 32'd8);
        bus.RegDst = 1'b1;
        #1;
        check("wreg_rd", 32'(bus.WriteReg), 32'd17);

        set_op(ALU_MULT, 32'd2, 32'd3);
        bus.Jal = 1'b1;
        #1;
        check("jal_res", bus.ALUResult, 32'h0040_0008);
        check("jal_wreg", 32'(bus.WriteReg), 32'd31);
        check("jal_stall", 32'(bus.Stall), 32'd0);
        next_cycle();
        check("jal_no_start", 32'(bus.Stall), 32'd0);

        set_op(ALU_MTHI, 32'hDEAD_BEEF, 32'h0);
        next_cycle();
        set_op(ALU_MTLO, 32'h1234_5678, 32'h0);
        next_cycle();
        set_op(5'h1F, 32'h0, 32'h0);
        next_cycle();
        set_op(ALU_MFHI, 32'h0, 32'h0);
        #1;
        check("mthi", bus.ALUResult, 32'hDEAD_BEEF);
        set_op(ALU_MFLO, 32'h0, 32'h0);
        #1;
        check("mtlo", bus.ALUResult, 32'h1234_5678);

        set_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
        #1;
        check("mult_res", bus.ALUResult, 32'h0);
        wait_mul("mult");
        next_cycle();
        set_op(ALU_MFHI, 32'h0, 32'h0);
        #1;
        check("mult_hi", bus.ALUResult, 32'hFFFF_FFFF);
        set_op(ALU_MFLO, 32'h0, 32'h0);
        #1;
        check("mult_lo", bus.ALUResult, 32'hFFFF_FFEB);

        set_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        wait_mul("multu");
        next_cycle();
        set_op(ALU_MFLO, 32'h0, 32'h0);
        #1;
        check("multu_no_restart", 32'(bus.Stall), 32'd0);
        check("multu_lo", bus.ALUResult, 32'h0000_0001);
        set_op(ALU_MFHI, 32'h0, 32'h0);
        #1;
        check("multu_hi", bus.ALUResult, 32'hFFFF_FFFE);

        set_op(ALU_MULT, 32'h0001_2345, 32'h0000_6789);
        #1;
        check("abort_issue", 32'(bus.Stall), 32'd1);
        for (int i = 0; i < 10; i++) next_cycle();
        check("abort_busy", 32'(bus.Stall), 32'd1);
        Reset = 1'b1;
        #1;
        check("abort_stall", 32'(bus.Stall), 32'd0);
        set_op(ALU_MFHI, 32'h0, 32'h0);
        #1;
        check("abort_hi", bus.ALUResult, 32'h0);
        set_op(ALU_MFLO, 32'h0, 32'h0);
        #1;
        check("abort_lo", bus.ALUResult, 32'h0);
        next_cycle();
        Reset = 1'b0;
        next_cycle();
        check("abort_idle", 32'(bus.Stall), 32'd0);

        set_op(ALU_MULT, 32'd2, 32'd3);
        #1;
        wait_mul("mult23");
        next_cycle();
        set_op(ALU_MFLO, 32'h0, 32'h0);
        #1;
        check("mult23_lo", bus.ALUResult, 32'd6);
        set_op(ALU_MFHI, 32'h0, 32'h0);
        #1;
        check("mult23_hi", bus.ALUResult, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
